// File: rtl/servo_slew_limiter.sv
// Three-channel angle rate limiter: each sign-magnitude output walks toward its
// clamped target by at most MAX_STEP degrees per prescaler tick.
module servo_slew_channel #(
    parameter int MAX_STEP     = 2,
    parameter int DEADBAND     = 1,
    parameter int ANGLE_MAX    = 90,
    parameter int SETTLE_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst_a_n,
    input  logic        i_enable,
    input  logic        i_tick,
    input  logic [15:0] i_tgt_abs,
    input  logic        i_tgt_neg,
    output logic [15:0] o_abs,
    output logic        o_neg,
    output logic        o_settled
);
    typedef enum logic [1:0] {MOVING, SETTLING, SETTLED} state_t;

    localparam int CW = $clog2(SETTLE_TICKS + 1);
    localparam logic signed [17:0] DB  = 18'(DEADBAND);
    localparam logic signed [17:0] STP = 18'(MAX_STEP);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic signed [17:0]    r_tgt_s, r_cur, w_cur_nxt, w_step;
    logic signed [17:0]    w_tgt_s, w_err, w_aerr;
    logic [15:0]           w_mag;

    // A negative zero target falls out as 0 because -0 == 0.
    assign w_mag   = (i_tgt_abs > 16'(ANGLE_MAX)) ? 16'(ANGLE_MAX) : i_tgt_abs;
    assign w_tgt_s = i_tgt_neg ? -$signed({2'b00, w_mag}) : $signed({2'b00, w_mag});

    assign w_err  = r_tgt_s - r_cur;
    assign w_aerr = w_err[17] ? -w_err : w_err;

    always_comb begin
        w_step = r_cur;
        if (w_aerr <= DB)
            w_step = r_cur;
        else if (w_aerr <= STP)
            w_step = r_tgt_s;
        else if (w_err[17])
            w_step = r_cur - STP;
        else
            w_step = r_cur + STP;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        if (!i_enable) begin
            w_cur_nxt   = r_tgt_s;
            w_state_nxt = SETTLED;
            w_cnt_nxt   = '0;
        end else if (i_tick) begin
            w_cur_nxt = w_step;
            if (w_step != r_cur) begin
                w_state_nxt = MOVING;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    MOVING: begin
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = (SETTLE_TICKS <= 1) ? SETTLED : SETTLING;
                    end
                    SETTLING: begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_cnt == CW'(SETTLE_TICKS - 1))
                            w_state_nxt = SETTLED;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_tgt_s <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_state <= MOVING;
        end else begin
            r_tgt_s <= w_tgt_s;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign o_abs     = 16'(r_cur[17] ? -r_cur : r_cur);
    assign o_neg     = r_cur[17];
    assign o_settled = (r_state == SETTLED);
endmodule

module servo_slew_limiter #(
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    parameter int STEP_RATE_HZ  = 1000,
    parameter int MAX_STEP      = 2,
    parameter int DEADBAND      = 1,
    parameter int ANGLE_MAX     = 90,
    parameter int SETTLE_TICKS  = 16
) (
    input  logic        clk,
    input  logic        rst_a_n,
    input  logic        enable,
    input  logic [15:0] tgt_abs_x,
    input  logic [15:0] tgt_abs_y,
    input  logic [15:0] tgt_abs_z,
    input  logic        tgt_neg_x,
    input  logic        tgt_neg_y,
    input  logic        tgt_neg_z,
    output logic [15:0] out_abs_x,
    output logic [15:0] out_abs_y,
    output logic [15:0] out_abs_z,
    output logic        out_neg_x,
    output logic        out_neg_y,
    output logic        out_neg_z,
    output logic [2:0]  settled,
    output logic        all_settled,
    output logic        step_tick
);
    localparam int TC = CLOCK_FREQ_HZ / STEP_RATE_HZ - 1;
    localparam int PW = (TC > 0) ? $clog2(TC + 1) : 1;

    logic [PW-1:0]       r_presc;
    logic                w_tick;
    logic [2:0][15:0]    w_tgt_abs, w_out_abs;
    logic [2:0]          w_tgt_neg, w_out_neg;

    assign w_tick = enable && (r_presc == PW'(TC));

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n)
            r_presc <= '0;
        else if (!enable || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + PW'(1);
    end

    assign w_tgt_abs = {tgt_abs_z, tgt_abs_y, tgt_abs_x};
    assign w_tgt_neg = {tgt_neg_z, tgt_neg_y, tgt_neg_x};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        servo_slew_channel #(
            .MAX_STEP    (MAX_STEP),
            .DEADBAND    (DEADBAND),
            .ANGLE_MAX   (ANGLE_MAX),
            .SETTLE_TICKS(SETTLE_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst_a_n  (rst_a_n),
            .i_enable (enable),
            .i_tick   (w_tick),
            .i_tgt_abs(w_tgt_abs[g]),
            .i_tgt_neg(w_tgt_neg[g]),
            .o_abs    (w_out_abs[g]),
            .o_neg    (w_out_neg[g]),
            .o_settled(settled[g])
        );
    end

    assign out_abs_x   = w_out_abs[0];
    assign out_abs_y   = w_out_abs[1];
    assign out_abs_z   = w_out_abs[2];
    assign out_neg_x   = w_out_neg[0];
    assign out_neg_y   = w_out_neg[1];
    assign out_neg_z   = w_out_neg[2];
    assign all_settled = &settled;
    assign step_tick   = w_tick;
endmodule

// File: tb/tb_servo_slew_limiter.sv
// Directed bench for servo_slew_limiter with a tick every 10 cycles.
module tb_servo_slew_limiter;
    logic        clk, rst_a_n, enable;
    logic [15:0] tgt_abs_x, tgt_abs_y, tgt_abs_z;
    logic        tgt_neg_x, tgt_neg_y, tgt_neg_z;
    logic [15:0] out_abs_x, out_abs_y, out_abs_z;
    logic        out_neg_x, out_neg_y, out_neg_z;
    logic [2:0]  settled;
    logic        all_settled, step_tick;

    int checks = 0;
    int errors = 0;

    servo_slew_limiter #(.CLOCK_FREQ_HZ(1000), .STEP_RATE_HZ(100)) dut (
        .clk(clk), .rst_a_n(rst_a_n), .enable(enable),
        .tgt_abs_x(tgt_abs_x), .tgt_abs_y(tgt_abs_y), .tgt_abs_z(tgt_abs_z),
        .tgt_neg_x(tgt_neg_x), .tgt_neg_y(tgt_neg_y), .tgt_neg_z(tgt_neg_z),
        .out_abs_x(out_abs_x), .out_abs_y(out_abs_y), .out_abs_z(out_abs_z),
        .out_neg_x(out_neg_x), .out_neg_y(out_neg_y), .out_neg_z(out_neg_z),
        .settled(settled), .all_settled(all_settled), .step_tick(step_tick)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, act, exp);
        end
    endtask

    // Wait for the next step tick, then sample just after the edge that applies it.
    task automatic tick();
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (step_tick) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("tick_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int e;
        rst_a_n = 1; enable = 1;
        tgt_abs_x = 0; tgt_abs_y = 0; tgt_abs_z = 0;
        tgt_neg_x = 0; tgt_neg_y = 0; tgt_neg_z = 0;
        #2 rst_a_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_abs_x", out_abs_x, 0);
        chk("rst_neg_x", out_neg_x, 0);
        chk("rst_settled", settled, 0);
        chk("rst_all", all_settled, 0);
        chk("rst_tick", step_tick, 0);
        @(negedge clk) rst_a_n = 1;

        // 1: idle targets settle after exactly 16 ticks
        tick();
        chk("tick_pulse", step_tick, 0);
        ticks(14);
        chk("t1_settled15", settled, 0);
        tick();
        chk("t1_settled16", settled, 3'b111);
        chk("t1_all16", all_settled, 1);
        chk("t1_abs_y", out_abs_y, 0);

        // 2: X ramps 0 -> 30
        tgt_abs_x = 30;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t2_ramp", out_abs_x, 2 * k);
            chk("t2_set0", settled[0], 0);
        end
        chk("t2_all", all_settled, 0);
        chk("t2_set_yz", settled[2:1], 2'b11);
        ticks(15);
        chk("t2_idle15", settled[0], 0);
        tick();
        chk("t2_idle16", settled[0], 1);
        chk("t2_all16", all_settled, 1);

        // 3: X crosses zero toward -10
        tgt_abs_x = 10; tgt_neg_x = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = 30 - 2 * k;
            chk("t3_abs", out_abs_x, (e < 0) ? -e : e);
            chk("t3_neg", out_neg_x, (e < 0) ? 1 : 0);
        end
        tick();
        chk("t3_hold", out_abs_x, 10);

        // 4: deadband and short final step
        tgt_abs_x = 30; tgt_neg_x = 0;
        ticks(20);
        chk("t4_at30", out_abs_x, 30);
        tgt_abs_x = 31;
        ticks(3);
        chk("t4_db31", out_abs_x, 30);
        tgt_abs_x = 33;
        tick();
        chk("t4_to32", out_abs_x, 32);
        chk("t4_mov", settled[0], 0);
        ticks(3);
        chk("t4_hold32", out_abs_x, 32);
        ticks(12);
        chk("t4_idle15", settled[0], 0);
        tick();
        chk("t4_idle16", settled[0], 1);

        // 5: Y clamps at 90; Z negative zero decodes as +0
        tgt_abs_y = 200;
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk("t5_y", out_abs_y, (2 * k > 90) ? 90 : 2 * k);
        end
        tgt_abs_z = 4; tgt_neg_z = 1;
        ticks(2);
        chk("t5_z4", out_abs_z, 4);
        chk("t5_zneg", out_neg_z, 1);
        tgt_abs_z = 0;
        ticks(2);
        chk("t5_z0", out_abs_z, 0);
        chk("t5_znz", out_neg_z, 0);

        // 6: bypass mid-ramp, then async reset
        tgt_abs_x = 80;
        ticks(3);
        chk("t6_ramp", out_abs_x, 38);
        enable = 0; tgt_abs_x = 45; tgt_neg_x = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_byp_abs", out_abs_x, 45);
        chk("t6_byp_neg", out_neg_x, 1);
        chk("t6_byp_set", settled, 3'b111);
        chk("t6_byp_all", all_settled, 1);
        chk("t6_byp_tick", step_tick, 0);
        #2 rst_a_n = 0;
        #1;
        chk("t6_rst_x", out_abs_x, 0);
        chk("t6_rst_nx", out_neg_x, 0);
        chk("t6_rst_y", out_abs_y, 0);
        chk("t6_rst_set", settled, 0);
        chk("t6_rst_all", all_settled, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
